mpsoc_msi_wb_burst_slave: RTL and testbench

MPSOC_MSI_WB_BURST_SLAVE -- requirements
Module: mpsoc_msi_wb_burst_slave

---
 rtl/mpsoc_msi_wb_burst_slave.sv | 155 +++++++++++++++
 tb/tb_mpsoc_msi_wb_burst_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_msi_wb_burst_slave.sv
// Wishbone B3 burst-capable memory slave with programmable wait states and wrap bursts.
// Optional MPSOC_MSI_WB_BURST_SLAVE_ERR_EN: out-of-range word addresses answer with err instead of ack.
module mpsoc_msi_wb_burst_slave #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o
);

    localparam int SW  = DW / 8;
    localparam int OFF = $clog2(SW);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [AW-1:0] wadr_q, wadr_d;
    logic          we_q, we_d;
    logic [2:0]    cti_q, cti_d;
    logic [1:0]    bte_q, bte_d;

    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] wadr_nxt;
    logic [IW-1:0] idx;
    logic          beat;
    logic          oor;
    logic          ack;
    logic          err;

    logic [DW-1:0] mem [DEPTH];

    // wadr_q holds the full word address so out-of-range detection sees the upper bits
    assign idx  = wadr_q[IW-1:0];
    assign beat = wb_cyc_i & wb_stb_i & ((state_q == S_ACK) || (state_q == S_BURST));

`ifdef MPSOC_MSI_WB_BURST_SLAVE_ERR_EN
    assign oor = (wadr_q >> IW) != '0;
`else
    assign oor = 1'b0;
`endif

    assign ack      = beat & ~oor;
    assign err      = beat & oor;
    assign wb_ack_o = ack;
    assign wb_err_o = err;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = ack ? mem[idx] : '0;

    always_comb begin
        case (bte_q)
            2'b01:   wrap_mask = AW'(3);
            2'b10:   wrap_mask = AW'(7);
            2'b11:   wrap_mask = AW'(15);
            default: wrap_mask = '1;
        endcase
        wadr_nxt = (wadr_q & ~wrap_mask) | ((wadr_q + AW'(1)) & wrap_mask);
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        wadr_d  = wadr_q;
        we_d    = we_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    wait_d  = 4'(WAIT_CYCLES);
                    wadr_d  = wb_adr_i >> OFF;
                    we_d    = wb_we_i;
                    cti_d   = wb_cti_i;
                    bte_d   = wb_bte_i;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q - 4'd1;
                    if (wait_q == 4'd1)
                        state_d = S_ACK;
                end
            end
            S_ACK, S_BURST: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wb_stb_i) begin
                    // first beat follows the latched cti, later beats end on live cti=111
                    if (oor || (wb_cti_i == 3'b111))
                        state_d = S_IDLE;
                    else if ((state_q == S_ACK) && (cti_q != 3'b001) && (cti_q != 3'b010))
                        state_d = S_IDLE;
                    else begin
                        state_d = S_BURST;
                        if (cti_q == 3'b010)
                            wadr_d = wadr_nxt;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            wadr_q  <= '0;
            we_q    <= 1'b0;
            cti_q   <= '0;
            bte_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wadr_q  <= wadr_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (ack && we_q) begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (wb_sel_i[i])
                    mem[idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_wb_burst_slave.sv
// Directed bench: one slave with no wait states, one with three, shared bus except cyc.
module tb_mpsoc_msi_wb_burst_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        stb = 1'b0;
    logic        cyc0 = 1'b0;
    logic        cyc3 = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;

    logic [31:0] dat0, dat3;
    logic        ack0, err0, rty0, ack3, err3, rty3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mpsoc_msi_wb_burst_slave #(.DW(32), .AW(32), .DEPTH(256), .WAIT_CYCLES(0)) u0 (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

    mpsoc_msi_wb_burst_slave #(.DW(32), .AW(32), .DEPTH(256), .WAIT_CYCLES(3)) u3 (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3));

    function automatic logic f_resp(bit d3);
        return d3 ? (ack3 | err3) : (ack0 | err0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic classic(input bit d3, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, output logic [31:0] rd, output int lat,
                           output bit early, output bit nxt, output bit got_err, output bit quiet);
        if (d3) cyc3 = 1'b1; else cyc0 = 1'b1;
        stb = 1'b1; we = w; adr = a; dat = wd; sel = s; cti = 3'b000; bte = 2'b00;
        #1;
        early = f_resp(d3);
        quiet = ((d3 ? dat3 : dat0) == 32'h0);
        lat = 0;
        while (lat < 40 && !f_resp(d3)) begin
            step();
            lat++;
            if (!f_resp(d3)) quiet = quiet && ((d3 ? dat3 : dat0) == 32'h0);
        end
        rd      = d3 ? dat3 : dat0;
        got_err = d3 ? err3 : err0;
        step();
        nxt = f_resp(d3);
        cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic burst4(input bit w, input logic [31:0] a, input logic [1:0] b,
                          input logic [31:0] wd [4], output logic [31:0] rd [4], output int nack);
        int lat;
        cyc0 = 1'b1; stb = 1'b1; we = w; adr = a; bte = b; cti = 3'b010; sel = 4'hF; dat = wd[0];
        lat = 0;
        while (lat < 40 && !ack0) begin
            step();
            lat++;
        end
        nack = 0;
        for (int i = 0; i < 4; i++) begin
            dat = wd[i];
            cti = (i == 3) ? 3'b111 : 3'b010;
            #1;
            rd[i] = dat0;
            if (ack0) nack++;
            step();
        end
        cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    endtask

    task automatic test_reset();
        cyc0 = 1'b1; cyc3 = 1'b1; stb = 1'b1; adr = 32'h10;
        step(); step();
        tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL rst_ack0 got=%b exp=0", ack0); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL rst_err0 got=%b exp=0", err0); end
        tests++; if (rty0 !== 1'b0) begin fails++; $display("FAIL rst_rty0 got=%b exp=0", rty0); end
        tests++; if (dat0 !== 32'h0) begin fails++; $display("FAIL rst_dat0 got=%h exp=0", dat0); end
        tests++; if (ack3 !== 1'b0) begin fails++; $display("FAIL rst_ack3 got=%b exp=0", ack3); end
        tests++; if (dat3 !== 32'h0) begin fails++; $display("FAIL rst_dat3 got=%h exp=0", dat3); end
        cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_classic();
        logic [31:0] rd; int lat; bit early, nxt, e, q;
        classic(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (lat !== 1) begin fails++; $display("FAIL w0_wr_lat got=%0d exp=1", lat); end
        tests++; if (nxt !== 1'b0) begin fails++; $display("FAIL w0_wr_single got=%b exp=0", nxt); end
        classic(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (lat !== 1) begin fails++; $display("FAIL w0_rd_lat got=%0d exp=1", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL w0_rd_data got=%h exp=deadbeef", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL w0_rd_err got=%b exp=0", e); end
        tests++; if (rty0 !== 1'b0) begin fails++; $display("FAIL w0_rty got=%b exp=0", rty0); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int lat; bit early, nxt, e, q;
        classic(1'b1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (lat !== 4) begin fails++; $display("FAIL w3_wr_lat got=%0d exp=4", lat); end
        classic(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (lat !== 4) begin fails++; $display("FAIL w3_rd_lat got=%0d exp=4", lat); end
        tests++; if (nxt !== 1'b0) begin fails++; $display("FAIL w3_single got=%b exp=0", nxt); end
        tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL w3_rd_data got=%h exp=0badf00d", rd); end
        tests++; if (q !== 1'b1) begin fails++; $display("FAIL w3_dat_zero_wait got=%b exp=1", q); end
    endtask

    task automatic test_wrap4_burst();
        logic [31:0] wd [4]; logic [31:0] rd [4]; logic [31:0] exp_rd [4]; int nack;
        wd = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_rd = '{32'd3, 32'd4, 32'd1, 32'd2};
        burst4(1'b1, 32'h08, 2'b01, wd, rd, nack);
        tests++; if (nack !== 4) begin fails++; $display("FAIL wrap_wr_acks got=%0d exp=4", nack); end
        wd = '{32'h0, 32'h0, 32'h0, 32'h0};
        burst4(1'b0, 32'h00, 2'b01, wd, rd, nack);
        tests++; if (nack !== 4) begin fails++; $display("FAIL wrap_rd_acks got=%0d exp=4", nack); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rd[i] !== exp_rd[i]) begin
                fails++; $display("FAIL wrap_rd_beat%0d got=%h exp=%h", i, rd[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_byte_sel();
        logic [31:0] rd; int lat; bit early, nxt, e, q;
        classic(1'b0, 1'b1, 32'h40, 32'hAAAAAAAA, 4'hF, rd, lat, early, nxt, e, q);
        classic(1'b0, 1'b1, 32'h40, 32'h12345678, 4'b0011, rd, lat, early, nxt, e, q);
        classic(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (rd !== 32'hAAAA5678) begin fails++; $display("FAIL sel_0011 got=%h exp=aaaa5678", rd); end
        classic(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, rd, lat, early, nxt, e, q);
        tests++; if (lat !== 1) begin fails++; $display("FAIL sel_0000_ack got=%0d exp=1", lat); end
        classic(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (rd !== 32'hAAAA5678) begin fails++; $display("FAIL sel_0000_nowrite got=%h exp=aaaa5678", rd); end
    endtask

    task automatic test_stall_abort();
        logic [31:0] rd; int lat; bit early, nxt, e, q;
        classic(1'b0, 1'b1, 32'h68, 32'h5555AAAA, 4'hF, rd, lat, early, nxt, e, q);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h60; bte = 2'b00; cti = 3'b010; sel = 4'hF; dat = 32'h11;
        lat = 0;
        while (lat < 40 && !ack0) begin step(); lat++; end
        tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL stall_beat0_ack got=%b exp=1", ack0); end
        step();
        dat = 32'h22; #1;
        tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL stall_beat1_ack got=%b exp=1", ack0); end
        step();
        stb = 1'b0; dat = 32'h33; #1;
        tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL stall_gap1_ack got=%b exp=0", ack0); end
        step();
        tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL stall_gap2_ack got=%b exp=0", ack0); end
        step();
        cyc0 = 1'b0; stb = 1'b1; #1;
        tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL stall_cycdrop_ack got=%b exp=0", ack0); end
        step();
        stb = 1'b0; we = 1'b0; cti = 3'b000;
        classic(1'b0, 1'b0, 32'h68, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (early !== 1'b0 || lat !== 1) begin
            fails++; $display("FAIL stall_idle_after got=early%b/lat%0d exp=early0/lat1", early, lat);
        end
        tests++; if (rd !== 32'h5555AAAA) begin fails++; $display("FAIL stall_no_extra_write got=%h exp=5555aaaa", rd); end
        classic(1'b0, 1'b0, 32'h64, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (rd !== 32'h22) begin fails++; $display("FAIL stall_beat1_data got=%h exp=22", rd); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] rd; int lat; bit early, nxt, e, q;
        classic(1'b0, 1'b1, 32'h84, 32'h77777777, 4'hF, rd, lat, early, nxt, e, q);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h80; bte = 2'b00; cti = 3'b010; sel = 4'hF; dat = 32'hA0A0A0A0;
        lat = 0;
        while (lat < 40 && !ack0) begin step(); lat++; end
        step();
        dat = 32'h99999999; #1;
        tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL rstmid_beat1_ack got=%b exp=1", ack0); end
        rst = 1'b0; #1;
        tests++; if (ack0 !== 1'b0 || dat0 !== 32'h0) begin
            fails++; $display("FAIL rstmid_abort got=ack%b/dat%h exp=ack0/dat0", ack0, dat0);
        end
        step();
        cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        rst = 1'b1;
        step();
        classic(1'b0, 1'b0, 32'h84, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (early !== 1'b0 || lat !== 1) begin
            fails++; $display("FAIL rstmid_new_req got=early%b/lat%0d exp=early0/lat1", early, lat);
        end
        tests++; if (rd !== 32'h77777777) begin fails++; $display("FAIL rstmid_no_write got=%h exp=77777777", rd); end
        classic(1'b0, 1'b0, 32'h80, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (rd !== 32'hA0A0A0A0) begin fails++; $display("FAIL rstmid_beat0 got=%h exp=a0a0a0a0", rd); end
    endtask

    task automatic test_err();
        logic [31:0] rd; int lat; bit early, nxt, e, q;
        classic(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, rd, lat, early, nxt, e, q);
        tests++; if (lat !== 1) begin fails++; $display("FAIL oor_lat got=%0d exp=1", lat); end
`ifdef MPSOC_MSI_WB_BURST_SLAVE_ERR_EN
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_err got=%b exp=1", e); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_dat got=%h exp=0", rd); end
`else
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL oor_err got=%b exp=0", e); end
        tests++; if (rd !== 32'd3) begin fails++; $display("FAIL oor_alias got=%h exp=3", rd); end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_classic();
        test_wait_states();
        test_wrap4_burst();
        test_byte_sel();
        test_stall_abort();
        test_reset_mid_burst();
        test_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
